// File: rtl/irq_encoder8to3_pkg.sv
// Shared definitions for the 8-to-3 request encoder: line/code widths,
// controller state encoding and the pick/one-hot helper functions.
package irq_encoder8to3_pkg;

    localparam int NUM_LINES = 8;
    localparam int CODE_W    = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Highest set bit wins; a later (higher) hit overrides an earlier one.
    function automatic logic [CODE_W-1:0] pick_fixed(input logic [NUM_LINES-1:0] p);
        logic [CODE_W-1:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_LINES; i++) begin
            idx = p[i] ? CODE_W'(i) : idx;
        end
        return idx;
    endfunction

    // Scan from last+8 (== last, lowest priority) down to last+1 so the
    // nearest set bit after last is the final one written.
    function automatic logic [CODE_W-1:0] pick_rr(input logic [NUM_LINES-1:0] p,
                                                  input logic [CODE_W-1:0]    last);
        logic [CODE_W-1:0] idx;
        logic [CODE_W-1:0] cand;
        idx = 3'd0;
        for (int k = NUM_LINES; k >= 1; k--) begin
            cand = last + CODE_W'(k);
            idx  = p[cand] ? cand : idx;
        end
        return idx;
    endfunction

    function automatic logic [NUM_LINES-1:0] onehot(input logic [CODE_W-1:0] c);
        return 8'd1 << c;
    endfunction

endpackage

// File: rtl/irq_encoder8to3_pick8.sv
// Combinational picker: selects one pending line by fixed priority or
// round-robin after the last granted index.
module irq_encoder8to3_pick8
    import irq_encoder8to3_pkg::*;
#(
    parameter bit RR_MODE = 1'b0
) (
    input  logic [NUM_LINES-1:0] pending,
    input  logic [CODE_W-1:0]    last,
    output logic [CODE_W-1:0]    idx,
    output logic                 any
);

    // Select the next index according to the arbitration mode.
    always_comb begin
        any = |pending;
        if (RR_MODE) begin
            idx = pick_rr(pending, last);
        end else begin
            idx = pick_fixed(pending);
        end
    end

endmodule

// File: rtl/irq_encoder8to3.sv
// Sequential 8-to-3 request encoder: sticky pending register, one grant at a
// time presented as a held code until acknowledged.
module irq_encoder8to3
    import irq_encoder8to3_pkg::*;
#(
    parameter bit RR_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LINES-1:0] req,
    input  logic                 en,
    input  logic                 ack,
    output logic [CODE_W-1:0]    code,
    output logic                 valid,
    output logic [NUM_LINES-1:0] pending
);

    state_t               state_r;
    logic [NUM_LINES-1:0] pending_r;
    logic [CODE_W-1:0]    code_r;
    logic [CODE_W-1:0]    last_r;
    logic                 valid_r;

    logic [NUM_LINES-1:0] clr_s;
    logic [NUM_LINES-1:0] pending_nxt_s;
    logic [CODE_W-1:0]    idx_s;
    logic                 any_s;

    irq_encoder8to3_pick8 #(
        .RR_MODE (RR_MODE)
    ) u_pick8 (
        .pending (pending_r),
        .last    (last_r),
        .idx     (idx_s),
        .any     (any_s)
    );

    // Pending update: an ack clears the granted line, a new request sets it (set wins).
    always_comb begin
        if (valid_r && ack) begin
            clr_s = onehot(code_r);
        end else begin
            clr_s = 8'h00;
        end
        pending_nxt_s = (pending_r & ~clr_s) | req;
    end

    // Grant controller and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 8'h00;
            code_r    <= 3'd0;
            last_r    <= 3'd7;
            valid_r   <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (en && any_s) begin
                        code_r  <= idx_s;
                        last_r  <= idx_s;
                        valid_r <= 1'b1;
                        state_r <= ST_BUSY;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    // Code is frozen here; en/req changes only matter after the ack.
                    if (ack) begin
                        valid_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign code    = code_r;
    assign valid   = valid_r;
    assign pending = pending_r;

endmodule

// File: doc/irq_encoder8to3.md
# irq_encoder8to3

Sequential 8-to-3 request encoder, the inverse of the RISC16 3-to-8 register/line-select decoder. Eight request lines are latched into a sticky pending register. One pending line is selected and presented as a 3-bit code with `valid`, and the code is held until the consumer acknowledges it. It sits between peripheral/interrupt request lines and the RISC16 control unit, which takes the code as a vector index or select.

## Interface
- `RR_MODE`, default 0: 0 = fixed priority, highest index wins; 1 = round-robin starting after the last granted index.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines, level-sampled every cycle; bit i is request i.
- `en`  in  1  grant enable; when low, no new grant is issued.
- `ack`  in  1  consumer acknowledge of the presented code; sampled only while `valid`=1.
- `code`  out  3  index of the granted request; registered.
- `valid`  out  1  `code` is meaningful and held; registered.
- `pending`  out  8  sticky pending register, for debug and status.

## Operation
- Pending update, every cycle, independent of `en`:
  - `pending_next = (pending & ~clr) | req`.
  - `clr` is the one-hot of `code` when `valid & ack`, otherwise 0.
  - If a bit is set and cleared in the same cycle, the set wins.
- State machine with two states, IDLE and BUSY:
  - IDLE: if `en`=1 and `pending`≠0, load `code` with the picked index, set `valid`=1, go to BUSY. Otherwise stay, with `valid`=0 and `code` holding its last value.
  - BUSY: `code` and `valid` hold regardless of `req`, `pending` or `en` changes. On `ack`=1, clear `pending[code]`, set `valid`=0, go to IDLE.
  - IDLE always lasts at least one cycle between grants.
- Pick rules:
  - Fixed priority (`RR_MODE`=0): highest set bit of `pending`.
  - Round-robin (`RR_MODE`=1): first set bit found scanning ascending, modulo 8, from `last+1`.
  - `last` updates to `code` on each grant.
  - Index wrap 7→0 uses 3-bit modulo arithmetic.
- `en` low in BUSY does not cancel the current grant; it only blocks the next grant.
- `ack` in IDLE is ignored.
- A `reset` assertion wins over everything, including mid-BUSY. Any outstanding grant is dropped without an ack.

## Timing
- Reset values:
  - `pending`=8'h00, `code`=3'b000, `valid`=0, state=IDLE.
  - `last`=3'd7, so the first round-robin scan starts at index 0.
- Latency: with `req[i]` high in cycle N, `pending[i]`=1 in N+1, and the earliest `valid`=1 with `code`=i is in N+2.
- Ack: with `ack` high in cycle M (BUSY), `valid`=0 and `pending[code]` is cleared in M+1. The next grant has `valid`=1 no earlier than M+2.
- Throughput: one grant per 2 cycles at best, when `ack` is returned in the first BUSY cycle.
- No combinational path from any input to any output.

## Structure
- Shared package or include `risc16_defs`:
  - `NUM_LINES`=8, `CODE_W`=3.
  - State encodings `ST_IDLE`=1'b0, `ST_BUSY`=1'b1.
- Sub-module `pick8`: a combinational picker taking `pending[7:0]`, `last[2:0]` and `RR_MODE`, and producing `idx[2:0]` and `any`.
- Estimated top-level RTL is 120–200 lines.

## Test plan
- Reset then idle:
  - Assert `reset` 2 cycles with `req`=8'hFF.
  - Required during reset: `valid`=0, `code`=0, `pending`=0.
  - Required after release: `pending`=8'hFF in the next cycle and `valid`=1 one cycle after that.
- Fixed priority, `RR_MODE`=0:
  - Pulse `req`=8'b0010_0100 for one cycle, `en`=1, and ack each grant immediately.
  - Required: grants `code`=5, then `code`=2, then `valid` stays 0 and `pending` ends at 0.
- Round-robin wrap, `RR_MODE`=1:
  - Hold `req`=8'b1000_0001 and ack each grant immediately.
  - Required: code sequence 0, 7, 0, 7…, with `last` wrapping 7→0.
- Hold in BUSY:
  - While `code`=3 is valid, raise `req[6]` and drop `en` for 4 cycles, then ack.
  - Required: `code` stays 3 with `valid` high throughout; `pending[6]` sets; no grant of 6 until `en` returns.
- Set/clear collision:
  - Assert `req[4]` in the same cycle as `ack` for `code`=4.
  - Required: `pending[4]` stays 1 and 4 is re-granted at M+2.
- Reset mid-BUSY:
  - Assert `reset` while `valid`=1 with `code`=5.
  - Required next cycle: `valid`=0, `pending`=0, state IDLE, and no ack required.
